ecc_err_monitor: RTL and testbench

Error-statistics and fault-capture stage placed directly downstream of the Hamming SEC-DED decoder. It samples the decoder's per-word error flags and syndrome whenever a read word is valid, keeps saturating single- and double-bit error counters, and captures the address and syndrome of the first (or most severe) error. It raises an interrupt on any uncorrectable error or when the single-bit error count reaches a threshold. Software clears it with a one-cycle pulse.

---
 rtl/ecc_err_monitor.sv | 140 ++++++++++++++
 tb/tb_ecc_err_monitor.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/ecc_err_monitor.sv
// Error statistics and fault capture behind a SEC-DED decoder: saturating SB/DB
// counters, first/most-severe error log, and a level interrupt cleared by software.
module ecc_err_monitor #(
    parameter int unsigned M         = 3,
    parameter int unsigned AW        = 8,
    parameter int unsigned CW        = 16,
    parameter int unsigned SB_THRESH = 8
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          valid_i,
    input  logic [AW-1:0] addr_i,
    input  logic [M:0]    syndrome_i,
    input  logic          sb_err_i,
    input  logic          db_err_i,
    input  logic          sb_fix_i,
    input  logic          clear_i,
    output logic [CW-1:0] sb_cnt_o,
    output logic [CW-1:0] db_cnt_o,
    output logic          log_valid_o,
    output logic [AW-1:0] log_addr_o,
    output logic [M:0]    log_syndrome_o,
    output logic          log_db_o,
    output logic          log_fix_o,
    output logic          irq_o
);

    localparam int unsigned SW = M + 1;
    localparam logic [CW-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_CLEAN  = 2'd0,
        ST_SB_LOG = 2'd1,
        ST_DB_LOG = 2'd2
    } state_e;

    state_e        state_q, state_d, state_base;
    logic [CW-1:0] sb_cnt_q, sb_cnt_d, sb_base;
    logic [CW-1:0] db_cnt_q, db_cnt_d, db_base;
    logic          log_valid_q, log_valid_d;
    logic [AW-1:0] log_addr_q, log_addr_d;
    logic [SW-1:0] log_syn_q, log_syn_d;
    logic          log_db_q, log_db_d;
    logic          log_fix_q, log_fix_d;
    logic          irq_q, irq_d;
    logic          ev_sb, ev_db, capture;

    // A DB flag dominates; SB only counts when the word is not uncorrectable.
    assign ev_db = valid_i & db_err_i;
    assign ev_sb = valid_i & sb_err_i & ~db_err_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_CLEAN;
        end else begin
            state_q <= state_d;
        end
    end

    // Clear is applied first, then any same-cycle event lands on the cleared state.
    always_comb begin
        state_base  = clear_i ? ST_CLEAN : state_q;
        sb_base     = clear_i ? '0 : sb_cnt_q;
        db_base     = clear_i ? '0 : db_cnt_q;
        state_d     = state_base;
        sb_cnt_d    = sb_base;
        db_cnt_d    = db_base;
        capture     = 1'b0;
        log_addr_d  = clear_i ? '0 : log_addr_q;
        log_syn_d   = clear_i ? '0 : log_syn_q;
        log_db_d    = clear_i ? 1'b0 : log_db_q;
        log_fix_d   = clear_i ? 1'b0 : log_fix_q;

        if (ev_sb && (sb_base != CNT_MAX)) sb_cnt_d = sb_base + CW'(1);
        if (ev_db && (db_base != CNT_MAX)) db_cnt_d = db_base + CW'(1);

        case (state_base)
            ST_CLEAN: begin
                if (ev_db) begin
                    state_d = ST_DB_LOG;
                    capture = 1'b1;
                end else if (ev_sb) begin
                    state_d = ST_SB_LOG;
                    capture = 1'b1;
                end
            end
            ST_SB_LOG: begin
                if (ev_db) begin
                    state_d = ST_DB_LOG;
                    capture = 1'b1;
                end
            end
            default: state_d = state_base;
        endcase

        if (capture) begin
            log_addr_d = addr_i;
            log_syn_d  = syndrome_i;
            log_db_d   = ev_db;
            log_fix_d  = sb_fix_i & ev_sb;
        end

        log_valid_d = (state_d != ST_CLEAN);
        irq_d       = (state_d == ST_DB_LOG) ||
                      ((SB_THRESH != 0) && (64'(sb_cnt_d) >= 64'(SB_THRESH)));
    end

    // Data registers; irq is registered from next state so it tracks the counters.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sb_cnt_q    <= '0;
            db_cnt_q    <= '0;
            log_valid_q <= 1'b0;
            log_addr_q  <= '0;
            log_syn_q   <= '0;
            log_db_q    <= 1'b0;
            log_fix_q   <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            sb_cnt_q    <= sb_cnt_d;
            db_cnt_q    <= db_cnt_d;
            log_valid_q <= log_valid_d;
            log_addr_q  <= log_addr_d;
            log_syn_q   <= log_syn_d;
            log_db_q    <= log_db_d;
            log_fix_q   <= log_fix_d;
            irq_q       <= irq_d;
        end
    end

    assign sb_cnt_o       = sb_cnt_q;
    assign db_cnt_o       = db_cnt_q;
    assign log_valid_o    = log_valid_q;
    assign log_addr_o     = log_addr_q;
    assign log_syndrome_o = log_syn_q;
    assign log_db_o       = log_db_q;
    assign log_fix_o      = log_fix_q;
    assign irq_o          = irq_q;

endmodule

// File: tb/tb_ecc_err_monitor.sv
// Randomized and directed bench for ecc_err_monitor; two instances (CW=16, CW=4)
// share stimulus and are compared against a severity-based reference model.
module tb_ecc_err_monitor;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       valid_i, sb_err_i, db_err_i, sb_fix_i, clear_i;
    logic [7:0] addr_i;
    logic [3:0] syndrome_i;

    logic [15:0] a_sb, a_db;
    logic [3:0]  b_sb, b_db;
    logic        a_lv, a_ldb, a_lfix, a_irq, b_lv, b_ldb, b_lfix, b_irq;
    logic [7:0]  a_laddr, b_laddr;
    logic [3:0]  a_lsyn, b_lsyn;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: counts as plain integers, log as "severity held" (0/1/2).
    int         m_sb, m_db, m_sb4, m_db4, m_sev;
    logic [7:0] m_addr;
    logic [3:0] m_syn;
    logic       m_dbf, m_fix;

    always #5 clk_i = ~clk_i;

    ecc_err_monitor #(.M(3), .AW(8), .CW(16), .SB_THRESH(8)) u_dut_a (
        .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .addr_i(addr_i),
        .syndrome_i(syndrome_i), .sb_err_i(sb_err_i), .db_err_i(db_err_i),
        .sb_fix_i(sb_fix_i), .clear_i(clear_i), .sb_cnt_o(a_sb), .db_cnt_o(a_db),
        .log_valid_o(a_lv), .log_addr_o(a_laddr), .log_syndrome_o(a_lsyn),
        .log_db_o(a_ldb), .log_fix_o(a_lfix), .irq_o(a_irq)
    );

    ecc_err_monitor #(.M(3), .AW(8), .CW(4), .SB_THRESH(8)) u_dut_b (
        .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .addr_i(addr_i),
        .syndrome_i(syndrome_i), .sb_err_i(sb_err_i), .db_err_i(db_err_i),
        .sb_fix_i(sb_fix_i), .clear_i(clear_i), .sb_cnt_o(b_sb), .db_cnt_o(b_db),
        .log_valid_o(b_lv), .log_addr_o(b_laddr), .log_syndrome_o(b_lsyn),
        .log_db_o(b_ldb), .log_fix_o(b_lfix), .irq_o(b_irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int sat_inc(input int v, input int maxv);
        return (v >= maxv) ? maxv : v + 1;
    endfunction

    task automatic model_reset();
        m_sb = 0; m_db = 0; m_sb4 = 0; m_db4 = 0; m_sev = 0;
        m_addr = '0; m_syn = '0; m_dbf = 1'b0; m_fix = 1'b0;
    endtask

    task automatic model_update();
        int ev;
        if (clear_i) model_reset();
        if (valid_i) begin
            ev = db_err_i ? 2 : (sb_err_i ? 1 : 0);
            if (ev == 1) begin
                m_sb  = sat_inc(m_sb, 65535);
                m_sb4 = sat_inc(m_sb4, 15);
            end
            if (ev == 2) begin
                m_db  = sat_inc(m_db, 65535);
                m_db4 = sat_inc(m_db4, 15);
            end
            if (ev > m_sev) begin
                m_sev  = ev;
                m_addr = addr_i;
                m_syn  = syndrome_i;
                m_dbf  = (ev == 2);
                m_fix  = sb_fix_i && (ev == 1);
            end
        end
    endtask

    task automatic check_all(input string ctx);
        logic lv;
        lv = (m_sev != 0);
        check({ctx, " a.sb_cnt"},   32'(a_sb),    32'(m_sb));
        check({ctx, " a.db_cnt"},   32'(a_db),    32'(m_db));
        check({ctx, " a.log_valid"},32'(a_lv),    32'(lv));
        check({ctx, " a.log_addr"}, 32'(a_laddr), 32'(m_addr));
        check({ctx, " a.log_syn"},  32'(a_lsyn),  32'(m_syn));
        check({ctx, " a.log_db"},   32'(a_ldb),   32'(m_dbf));
        check({ctx, " a.log_fix"},  32'(a_lfix),  32'(m_fix));
        check({ctx, " a.irq"},      32'(a_irq),   32'((m_sev == 2) || (m_sb >= 8)));
        check({ctx, " b.sb_cnt"},   32'(b_sb),    32'(m_sb4));
        check({ctx, " b.db_cnt"},   32'(b_db),    32'(m_db4));
        check({ctx, " b.log_valid"},32'(b_lv),    32'(lv));
        check({ctx, " b.log_addr"}, 32'(b_laddr), 32'(m_addr));
        check({ctx, " b.log_syn"},  32'(b_lsyn),  32'(m_syn));
        check({ctx, " b.log_db"},   32'(b_ldb),   32'(m_dbf));
        check({ctx, " b.log_fix"},  32'(b_lfix),  32'(m_fix));
        check({ctx, " b.irq"},      32'(b_irq),   32'((m_sev == 2) || (m_sb4 >= 8)));
    endtask

    // One cycle: drive at negedge, model at posedge, check 1 time unit later.
    task automatic step(input string ctx, input logic v, input logic [7:0] a,
                        input logic [3:0] s, input logic sb, input logic db,
                        input logic fix, input logic clr);
        @(negedge clk_i);
        valid_i = v; addr_i = a; syndrome_i = s;
        sb_err_i = sb; db_err_i = db; sb_fix_i = fix; clear_i = clr;
        @(posedge clk_i);
        model_update();
        #1;
        check_all(ctx);
    endtask

    task automatic do_clear();
        step("clear", 1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        rst_ni = 1'b0;
        valid_i = 0; addr_i = '0; syndrome_i = '0;
        sb_err_i = 0; db_err_i = 0; sb_fix_i = 0; clear_i = 0;
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        check_all("reset");
        @(negedge clk_i);
        rst_ni = 1'b1;

        for (int i = 0; i < 10; i++)
            step("idle", 1'b1, 8'($urandom), 4'($urandom), 1'b0, 1'b0, 1'($urandom), 1'b0);

        step("sb_first",  1'b1, 8'h12, 4'b0111, 1'b1, 1'b0, 1'b1, 1'b0);
        step("sb_second", 1'b1, 8'h34, 4'b0011, 1'b1, 1'b0, 1'b0, 1'b0);

        do_clear();
        step("sb_pre_db", 1'b1, 8'h12, 4'b0111, 1'b1, 1'b0, 1'b1, 1'b0);
        step("db_over",   1'b1, 8'h40, 4'b0110, 1'b0, 1'b1, 1'b0, 1'b0);
        step("db_sticky", 1'b1, 8'h41, 4'b1110, 1'b1, 1'b1, 1'b1, 1'b0);

        do_clear();
        for (int i = 0; i < 8; i++)
            step("sb_thresh", 1'b1, 8'(i), 4'($urandom), 1'b1, 1'b0, 1'($urandom), 1'b0);
        do_clear();

        step("pre_coinc",  1'b1, 8'h20, 4'h5, 1'b1, 1'b0, 1'b1, 1'b0);
        step("clr_coinc",  1'b1, 8'h55, 4'hA, 1'b0, 1'b1, 1'b0, 1'b1);

        do_clear();
        for (int i = 0; i < 20; i++)
            step("sb_sat", 1'b1, 8'($urandom), 4'($urandom), 1'b1, 1'b0, 1'($urandom), 1'b0);

        // Asynchronous reset in the middle of a cycle, away from any edge.
        @(posedge clk_i);
        #3;
        rst_ni = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk_i);
        valid_i = 0; sb_err_i = 0; db_err_i = 0; clear_i = 0;
        @(negedge clk_i);
        rst_ni = 1'b1;

        for (int i = 0; i < 400; i++) begin
            logic v, sb, db, clr;
            v   = ($urandom_range(0, 3) != 0);
            sb  = ($urandom_range(0, 2) == 0);
            db  = ($urandom_range(0, 11) == 0);
            clr = ($urandom_range(0, 24) == 0);
            step("rand", v, 8'($urandom), 4'($urandom), sb, db, 1'($urandom), clr);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
